// File: rtl/palmpilot_pkg.sv
// Board-wide constants and the button FSM encoding shared by every
// conditioner instance on the PalmPilot Basys3 design.
package palmpilot_pkg;

    localparam int unsigned CLK_HZ = 100_000_000;

    // 10 ms debounce window and 1 s long-hold threshold at the board clock.
    localparam int unsigned BTN_DEBOUNCE_CYCLES = CLK_HZ / 100;
    localparam int unsigned BTN_HOLD_CYCLES     = CLK_HZ;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for one asynchronous pin; shared by the board
// buttons and switches.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces the raw push-button, producing a clean level
// and one-cycle press, release and long-hold pulses.
module button_conditioner
    import palmpilot_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = BTN_HOLD_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       btn_press,
    output logic       btn_release,
    output logic       btn_hold,
    output btn_state_t dbg_state
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic btn_s;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_raw),
        .q_o   (btn_s)
    );

    btn_state_t        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_done_q, hold_done_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              hold_q, hold_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            hold_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            hold_done_q <= hold_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        hold_done_d = hold_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        hold_d      = 1'b0;

        // The hold counter saturates at its threshold; hold_done stops re-firing.
        if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
            if (hold_cnt_q == HOLD_LAST) begin
                if (!hold_done_q) begin
                    hold_d      = 1'b1;
                    hold_done_d = 1'b1;
                end
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = DB_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                    press_d  = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = DB_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = IDLE;
                    db_cnt_d    = '0;
                    release_d   = 1'b1;
                    hold_cnt_d  = '0;
                    hold_done_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_hold    = hold_q;
    assign dbg_state   = state_q;

endmodule
